// File: rtl/audio_seq_ctrl_pkg.sv
// Shared types, constants and helpers for the audio record/playback control path.
package audio_seq_ctrl_pkg;

  // Default codec SRAM word-address width and the largest legal speed factor
  localparam int unsigned DEF_ADDR_W   = 18;
  localparam int unsigned DEF_MAX_RATE = 8;
  localparam int unsigned RATE_W       = 4;

  // Sequencer modes; the encoding is visible on the state port
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RECORD = 2'b01,
    S_PLAY   = 2'b10,
    S_FULL   = 2'b11
  } seq_state_e;

  // Map a requested speed factor onto the legal range 1..max_rate
  function automatic logic [RATE_W-1:0] clamp_rate(input logic [RATE_W-1:0] req,
                                                   input logic [RATE_W-1:0] max_rate);
    logic [RATE_W-1:0] r;
    r = req;
    if (req == '0) begin
      r = RATE_W'(1);
    end else if (req > max_rate) begin
      r = max_rate;
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_seq_ctrl_sample_timer.sv
// Elapsed-seconds timer driven by DACLRCK rising edges in the bit-clock domain.
module audio_seq_ctrl_sample_timer #(
  parameter int unsigned SAMPLE_RATE = 32000,
  parameter int unsigned SEC_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lrck,
  input  logic             clear,
  input  logic             enable,
  output logic [SEC_W-1:0] seconds
);

  localparam int unsigned CNT_W = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;

  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rise;

  assign rise = lrck & ~prev_q;

  // Edge detect, count samples per second and saturate the seconds count
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      seconds <= '0;
    end else begin
      prev_q <= lrck;
      if (clear) begin
        cnt_q   <= '0;
        seconds <= '0;
      end else if (enable && rise) begin
        if (cnt_q == CNT_W'(SAMPLE_RATE - 1)) begin
          cnt_q <= '0;
          if (seconds != '1) begin
            seconds <= seconds + 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/audio_seq_ctrl.sv
// Record/playback sequencer driving the codec control inputs from key pulses.
module audio_seq_ctrl
  import audio_seq_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned SAMPLE_RATE = 32000,
  parameter int unsigned SEC_W       = 8,
  parameter int unsigned MAX_RATE    = DEF_MAX_RATE
) (
  input  logic              AUD_BCLK,
  input  logic              rst,
  input  logic              AUD_DACLRCK,
  input  logic              key_record,
  input  logic              key_play,
  input  logic              key_stop,
  input  logic [3:0]        sw_rate,
  input  logic              sw_fast,
  input  logic              sw_interp,
  input  logic [ADDR_W-1:0] codec_addr,
  output logic              stop,
  output logic              record,
  output logic              fast,
  output logic [3:0]        rate,
  output logic              interp,
  output logic [1:0]        state,
  output logic [ADDR_W-1:0] rec_end_addr,
  output logic [SEC_W-1:0]  seconds
);

  seq_state_e        state_q, state_d;
  logic              hold_q, hold_d;
  logic              stop_d, record_d, fast_d, interp_d;
  logic [3:0]        rate_d;
  logic [ADDR_W-1:0] rec_end_d;
  logic              entering;
  logic              timer_clear;
  logic              timer_enable;

  assign state        = 2'(state_q);
  assign timer_enable = (state_q == S_RECORD) || (state_q == S_PLAY);

  // State and output registers
  always_ff @(posedge AUD_BCLK) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hold_q       <= 1'b0;
      stop         <= 1'b1;
      record       <= 1'b0;
      fast         <= 1'b0;
      rate         <= 4'd1;
      interp       <= 1'b0;
      rec_end_addr <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      stop         <= stop_d;
      record       <= record_d;
      fast         <= fast_d;
      rate         <= rate_d;
      interp       <= interp_d;
      rec_end_addr <= rec_end_d;
    end
  end

  // Next mode from key pulses (stop > record > play) and codec address
  always_comb begin
    state_d = state_q;
    hold_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_stop) begin
          state_d = S_IDLE;
        end else if (key_record) begin
          state_d = S_RECORD;
        end else if (key_play && (rec_end_addr != '0)) begin
          state_d = S_PLAY;
        end
      end
      S_RECORD: begin
        if (key_stop) begin
          state_d = S_IDLE;
        end else if (codec_addr == '1) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (key_stop) begin
          state_d = S_IDLE;
        end else if (key_play) begin
          // One clearing cycle so the codec restarts from address 0
          state_d = S_PLAY;
          hold_d  = 1'b1;
        end
      end
      S_PLAY: begin
        // Address check is skipped while the codec is still being cleared
        if (key_stop) begin
          state_d = S_IDLE;
        end else if (!hold_q && (codec_addr >= rec_end_addr)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the codec controls, end address and timer clear
  always_comb begin
    fast_d      = fast;
    rate_d      = rate;
    interp_d    = interp;
    rec_end_d   = rec_end_addr;
    timer_clear = 1'b0;
    entering    = (state_d != state_q);
    stop_d      = (state_d == S_IDLE) || hold_d;
    record_d    = (state_d == S_RECORD) || (state_d == S_FULL);
    if ((state_q == S_RECORD) && (state_d == S_IDLE)) begin
      rec_end_d = codec_addr;
    end else if ((state_q == S_RECORD) && (state_d == S_FULL)) begin
      rec_end_d = '1;
    end
    if (entering) begin
      case (state_d)
        S_RECORD: begin
          fast_d      = 1'b0;
          interp_d    = 1'b0;
          timer_clear = 1'b1;
        end
        S_PLAY: begin
          fast_d      = sw_fast;
          interp_d    = sw_fast ? 1'b0 : sw_interp;
          rate_d      = clamp_rate(sw_rate, 4'(MAX_RATE));
          timer_clear = 1'b1;
        end
        default: timer_clear = 1'b0;
      endcase
    end
  end

  audio_seq_ctrl_sample_timer #(
    .SAMPLE_RATE(SAMPLE_RATE),
    .SEC_W      (SEC_W)
  ) u_sample_timer (
    .clk    (AUD_BCLK),
    .rst    (rst),
    .lrck   (AUD_DACLRCK),
    .clear  (timer_clear),
    .enable (timer_enable),
    .seconds(seconds)
  );

endmodule

// File: tb/tb_audio_seq_ctrl.sv
// Testbench for audio_seq_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_audio_seq_ctrl;

  localparam int unsigned ADDR_W   = 18;
  localparam int unsigned SR       = 4;
  localparam int unsigned SEC_W    = 8;
  localparam int unsigned MAXR     = 8;
  localparam int unsigned VW       = 2 + 1 + 1 + 1 + 4 + 1 + ADDR_W + SEC_W;
  localparam int          ADDR_MAX = (1 << ADDR_W) - 1;
  localparam int          SEC_MAX  = (1 << SEC_W) - 1;
  localparam logic [VW-1:0] RESET_VEC = {2'b00, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0,
                                         {ADDR_W{1'b0}}, {SEC_W{1'b0}}};

  logic              AUD_BCLK = 1'b0;
  logic              rst = 1'b1;
  logic              AUD_DACLRCK = 1'b0;
  logic              key_record = 1'b0, key_play = 1'b0, key_stop = 1'b0;
  logic [3:0]        sw_rate = 4'd0;
  logic              sw_fast = 1'b0, sw_interp = 1'b0;
  logic [ADDR_W-1:0] codec_addr = '0;
  logic              stop, record, fast, interp;
  logic [3:0]        rate;
  logic [1:0]        state;
  logic [ADDR_W-1:0] rec_end_addr;
  logic [SEC_W-1:0]  seconds;
  logic [VW-1:0]     obs;

  int checks = 0;
  int passed = 0;

  // Behavioural model: mode 0 idle, 1 record, 2 play, 3 full
  int m_mode = 0, m_rate = 1, m_end = 0, m_samp = 0, m_secs = 0;
  bit m_hold = 0, m_stop = 1, m_record = 0, m_fast = 0, m_interp = 0, m_prev = 0;

  always #5 AUD_BCLK = ~AUD_BCLK;

  assign obs = {state, stop, record, fast, rate, interp, rec_end_addr, seconds};

  audio_seq_ctrl #(
    .ADDR_W     (ADDR_W),
    .SAMPLE_RATE(SR),
    .SEC_W      (SEC_W),
    .MAX_RATE   (MAXR)
  ) dut (
    .AUD_BCLK    (AUD_BCLK),
    .rst         (rst),
    .AUD_DACLRCK (AUD_DACLRCK),
    .key_record  (key_record),
    .key_play    (key_play),
    .key_stop    (key_stop),
    .sw_rate     (sw_rate),
    .sw_fast     (sw_fast),
    .sw_interp   (sw_interp),
    .codec_addr  (codec_addr),
    .stop        (stop),
    .record      (record),
    .fast        (fast),
    .rate        (rate),
    .interp      (interp),
    .state       (state),
    .rec_end_addr(rec_end_addr),
    .seconds     (seconds)
  );

  function automatic logic [VW-1:0] exp_vec();
    return {2'(m_mode), m_stop, m_record, m_fast, 4'(m_rate), m_interp,
            ADDR_W'(m_end), SEC_W'(m_secs)};
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge
  task automatic model_edge();
    int  old_mode, new_mode, addr;
    bit  rise, hold_now;
    if (rst) begin
      m_mode = 0; m_hold = 0; m_stop = 1; m_record = 0; m_fast = 0; m_rate = 1;
      m_interp = 0; m_end = 0; m_samp = 0; m_secs = 0; m_prev = 0;
    end else begin
      rise     = AUD_DACLRCK && !m_prev;
      m_prev   = AUD_DACLRCK;
      old_mode = m_mode;
      new_mode = m_mode;
      addr     = int'(codec_addr);
      hold_now = 0;
      if (old_mode == 0) begin
        if (!key_stop && key_record) new_mode = 1;
        else if (!key_stop && key_play && m_end != 0) new_mode = 2;
      end else if (old_mode == 1) begin
        if (key_stop) begin new_mode = 0; m_end = addr; end
        else if (addr == ADDR_MAX) begin new_mode = 3; m_end = ADDR_MAX; end
      end else if (old_mode == 3) begin
        if (key_stop) new_mode = 0;
        else if (key_play) begin new_mode = 2; hold_now = 1; end
      end else begin
        if (key_stop) new_mode = 0;
        else if (!m_hold && addr >= m_end) new_mode = 0;
      end
      if (new_mode != old_mode && (new_mode == 1 || new_mode == 2)) begin
        m_samp = 0;
        m_secs = 0;
      end else if ((old_mode == 1 || old_mode == 2) && rise) begin
        m_samp = m_samp + 1;
        if (m_samp == SR) begin
          m_samp = 0;
          if (m_secs < SEC_MAX) m_secs = m_secs + 1;
        end
      end
      if (new_mode != old_mode && new_mode == 1) begin
        m_fast = 0; m_interp = 0;
      end
      if (new_mode != old_mode && new_mode == 2) begin
        m_fast   = sw_fast;
        m_interp = sw_fast ? 1'b0 : sw_interp;
        m_rate   = (sw_rate == 0) ? 1 : ((int'(sw_rate) > MAXR) ? MAXR : int'(sw_rate));
      end
      m_hold   = hold_now;
      m_mode   = new_mode;
      m_stop   = (new_mode == 0) || hold_now;
      m_record = (new_mode == 1) || (new_mode == 3);
    end
  endtask

  task automatic tick();
    @(posedge AUD_BCLK);
    model_edge();
    #1;
    key_record = 1'b0;
    key_play   = 1'b0;
    key_stop   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (obs !== RESET_VEC) $display("FAIL reset_values: got %h expected %h", obs, RESET_VEC); else passed++;
    key_play = 1'b1; tick();
    checks++; if ({state, stop} !== 3'b001) $display("FAIL play_nothing_recorded: got %b expected 001", {state, stop}); else passed++;
    checks++; if (obs !== exp_vec()) $display("FAIL reset_model: got %h expected %h", obs, exp_vec()); else passed++;
  endtask

  task automatic test_record_stop();
    codec_addr = '0; key_record = 1'b1; tick();
    checks++; if ({state, stop, record} !== 4'b0101) $display("FAIL record_entry: got %b expected 0101", {state, stop, record}); else passed++;
    codec_addr = ADDR_W'(18'h00123); tick();
    key_stop = 1'b1; tick();
    checks++; if ({state, stop} !== 3'b001) $display("FAIL record_stop_state: got %b expected 001", {state, stop}); else passed++;
    checks++; if (rec_end_addr !== ADDR_W'(18'h00123)) $display("FAIL record_end_addr: got %h expected 00123", rec_end_addr); else passed++;
    checks++; if (obs !== exp_vec()) $display("FAIL record_model: got %h expected %h", obs, exp_vec()); else passed++;
  endtask

  task automatic test_play_auto_end();
    codec_addr = '0; sw_rate = 4'd0; sw_fast = 1'b1; sw_interp = 1'b1; key_play = 1'b1; tick();
    checks++; if ({state, stop, fast, rate, interp} !== 9'b10_0_1_0001_0) $display("FAIL play_fast_settings: got %b expected 100100010", {state, stop, fast, rate, interp}); else passed++;
    codec_addr = ADDR_W'(18'h00124); tick();
    checks++; if ({state, stop} !== 3'b001) $display("FAIL play_past_end: got %b expected 001", {state, stop}); else passed++;
    codec_addr = '0; key_play = 1'b1; tick();
    codec_addr = ADDR_W'(18'h00122); tick();
    checks++; if (state !== 2'b10) $display("FAIL play_below_end: got %b expected 10", state); else passed++;
    codec_addr = ADDR_W'(18'h00123); tick();
    checks++; if ({state, stop} !== 3'b001) $display("FAIL play_at_end: got %b expected 001", {state, stop}); else passed++;
  endtask

  task automatic test_full();
    codec_addr = '0; key_record = 1'b1; tick();
    codec_addr = '1; tick();
    checks++; if ({state, stop, record} !== 4'b1101) $display("FAIL full_entry: got %b expected 1101", {state, stop, record}); else passed++;
    checks++; if (rec_end_addr !== {ADDR_W{1'b1}}) $display("FAIL full_end_addr: got %h expected 3ffff", rec_end_addr); else passed++;
    key_record = 1'b1; tick();
    checks++; if (state !== 2'b11) $display("FAIL full_ignores_record: got %b expected 11", state); else passed++;
    key_play = 1'b1; tick();
    checks++; if ({state, stop, record} !== 4'b1010) $display("FAIL full_play_hold: got %b expected 1010", {state, stop, record}); else passed++;
    tick();
    checks++; if ({state, stop} !== 3'b100) $display("FAIL full_play_release: got %b expected 100", {state, stop}); else passed++;
    codec_addr = '0; tick();
    checks++; if (obs !== exp_vec()) $display("FAIL full_play_model: got %h expected %h", obs, exp_vec()); else passed++;
    key_stop = 1'b1; tick();
  endtask

  task automatic test_rate_clamp();
    sw_rate = 4'd12; sw_fast = 1'b0; sw_interp = 1'b1; key_play = 1'b1; tick();
    checks++; if ({rate, interp, fast} !== 6'b1000_1_0) $display("FAIL clamp_high: got %b expected 100010", {rate, interp, fast}); else passed++;
    sw_rate = 4'd3; sw_fast = 1'b1; sw_interp = 1'b0; tick();
    checks++; if ({rate, interp, fast} !== 6'b1000_1_0) $display("FAIL settings_locked: got %b expected 100010", {rate, interp, fast}); else passed++;
    key_stop = 1'b1; tick();
    sw_rate = 4'd5; sw_fast = 1'b0; sw_interp = 1'b0; key_play = 1'b1; tick();
    checks++; if ({rate, interp} !== 5'b0101_0) $display("FAIL rate_passthrough: got %b expected 01010", {rate, interp}); else passed++;
    key_stop = 1'b1; tick();
  endtask

  task automatic test_seconds();
    AUD_DACLRCK = 1'b0; codec_addr = '0; key_play = 1'b1; tick();
    for (int i = 0; i < 9; i++) begin
      AUD_DACLRCK = 1'b1; tick();
      AUD_DACLRCK = 1'b0; tick();
    end
    checks++; if ({state, seconds} !== {2'b10, SEC_W'(2)}) $display("FAIL seconds_nine_edges: got %h expected %h", {state, seconds}, {2'b10, SEC_W'(2)}); else passed++;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (obs !== RESET_VEC) $display("FAIL reset_mid_play: got %h expected %h", obs, RESET_VEC); else passed++;
  endtask

  task automatic test_key_priority();
    key_stop = 1'b1; key_record = 1'b1; tick();
    checks++; if ({state, stop} !== 3'b001) $display("FAIL stop_beats_record: got %b expected 001", {state, stop}); else passed++;
    key_record = 1'b1; key_play = 1'b1; tick();
    checks++; if (state !== 2'b01) $display("FAIL record_beats_play: got %b expected 01", state); else passed++;
    key_stop = 1'b1; tick();
  endtask

  task automatic test_saturation();
    codec_addr = '0; AUD_DACLRCK = 1'b0; key_record = 1'b1; tick();
    for (int i = 0; i < (SEC_MAX + 3) * SR; i++) begin
      AUD_DACLRCK = 1'b1; tick();
      AUD_DACLRCK = 1'b0; tick();
    end
    checks++; if (seconds !== SEC_W'(SEC_MAX)) $display("FAIL seconds_saturate: got %0d expected %0d", seconds, SEC_MAX); else passed++;
    key_stop = 1'b1; tick();
    AUD_DACLRCK = 1'b1; tick(); AUD_DACLRCK = 1'b0; tick();
    checks++; if ({state, seconds} !== {2'b00, SEC_W'(SEC_MAX)}) $display("FAIL seconds_hold_idle: got %h expected %h", {state, seconds}, {2'b00, SEC_W'(SEC_MAX)}); else passed++;
    key_record = 1'b1; tick();
    checks++; if (seconds !== '0) $display("FAIL seconds_clear_entry: got %0d expected 0", seconds); else passed++;
    key_stop = 1'b1; tick();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      key_record  = ($urandom_range(0, 99) < 4);
      key_play    = ($urandom_range(0, 99) < 6);
      key_stop    = ($urandom_range(0, 99) < 3);
      sw_rate     = 4'($urandom_range(0, 15));
      sw_fast     = 1'($urandom_range(0, 1));
      sw_interp   = 1'($urandom_range(0, 1));
      AUD_DACLRCK = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      if (stop) codec_addr = '0;
      else if (r < 2) codec_addr = '1;
      else if (r < 5) codec_addr = ADDR_W'($urandom);
      else codec_addr = codec_addr + ADDR_W'($urandom_range(0, 3));
      tick();
      checks++; if (obs !== exp_vec()) $display("FAIL random_cycle_%0d: got %h expected %h", i, obs, exp_vec()); else passed++;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_record_stop();
    test_play_auto_end();
    test_full();
    test_rate_clamp();
    test_seconds();
    test_key_priority();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
